// File: rtl/load_store_multi.sv
// Multi-channel volume tracker: per-channel up/down counters stepped in
// triangle, saw, one-shot or hold mode, with at-limit flags and a global peak count.
module load_store_ch #(
  parameter int CBITS = 15,
  parameter int N     = 25000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             step_i,
  input  logic             cfg_hit_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic [CBITS-1:0] cfg_limit_i,
  output logic [CBITS-1:0] vol_o,
  output logic             dir_o,
  output logic             sig_o,
  output logic             done_o,
  output logic             rise_o
);
  typedef enum logic [1:0] {M_TRI = 2'd0, M_SAW = 2'd1, M_ONE = 2'd2, M_HOLD = 2'd3} mode_e;
  localparam logic [CBITS-1:0] NL = CBITS'(N);

  logic [CBITS-1:0] vol_q, vol_d, lim_q, lim_d;
  logic             dir_q, dir_d, sig_q, sig_d, done_q, done_d;
  mode_e            mode_q, mode_d;

  always_comb begin
    vol_d  = vol_q;
    dir_d  = dir_q;
    lim_d  = lim_q;
    mode_d = mode_q;
    done_d = done_q;
    if (cfg_hit_i) begin
      lim_d  = cfg_limit_i;
      mode_d = mode_e'(cfg_mode_i);
      vol_d  = '0;
      dir_d  = 1'b0;
      done_d = 1'b0;
    end else if (step_i) begin
      unique case (mode_q)
        M_TRI: begin
          // turnarounds dwell one cycle at each extreme
          if (dir_q) begin
            if (vol_q >= lim_q) dir_d = 1'b0;
            else                vol_d = vol_q + 1'b1;
          end else begin
            if (vol_q == '0)    dir_d = 1'b1;
            else                vol_d = vol_q - 1'b1;
          end
        end
        M_SAW: begin
          dir_d = 1'b1;
          vol_d = (vol_q >= lim_q) ? '0 : vol_q + 1'b1;
        end
        M_ONE: begin
          dir_d = 1'b1;
          if (vol_q < lim_q) vol_d = vol_q + 1'b1;
          done_d = done_q | (vol_d >= lim_q);
        end
        default: ;
      endcase
    end
    sig_d = (vol_d == lim_d);
  end

  assign rise_o = sig_d & ~sig_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vol_q  <= '0;
      dir_q  <= 1'b0;
      lim_q  <= NL;
      mode_q <= M_TRI;
      done_q <= 1'b0;
      sig_q  <= (NL == '0);
    end else begin
      vol_q  <= vol_d;
      dir_q  <= dir_d;
      lim_q  <= lim_d;
      mode_q <= mode_d;
      done_q <= done_d;
      sig_q  <= sig_d;
    end
  end

  assign vol_o  = vol_q;
  assign dir_o  = dir_q;
  assign sig_o  = sig_q;
  assign done_o = done_q;
endmodule

module load_store_multi #(
  parameter int NUM_CH = 4,
  parameter int CBITS  = 15,
  parameter int N      = 25000,
  parameter int PCBITS = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic                    cfg_we_i,
  input  logic [3:0]              cfg_ch_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [CBITS-1:0]        cfg_limit_i,
  input  logic                    peak_clr_i,
  output logic [NUM_CH*CBITS-1:0] vol_o,
  output logic [NUM_CH-1:0]       dir_o,
  output logic [NUM_CH-1:0]       sig_o,
  output logic [NUM_CH-1:0]       done_o,
  output logic [PCBITS-1:0]       peak_cnt_o
);
  localparam int SW = PCBITS + 5;
  localparam logic [PCBITS-1:0] PMAX = {PCBITS{1'b1}};

  logic [NUM_CH-1:0] cfg_hit, rise;
  logic [SW-1:0]     sum;
  logic [PCBITS-1:0] peak_q, peak_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // out-of-range cfg_ch matches no channel, so the write is dropped
    assign cfg_hit[g] = cfg_we_i && (cfg_ch_i == 4'(g));
    load_store_ch #(.CBITS(CBITS), .N(N)) u_ch (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .step_i      (en_i[g] & ~cfg_hit[g]),
      .cfg_hit_i   (cfg_hit[g]),
      .cfg_mode_i  (cfg_mode_i),
      .cfg_limit_i (cfg_limit_i),
      .vol_o       (vol_o[g*CBITS +: CBITS]),
      .dir_o       (dir_o[g]),
      .sig_o       (sig_o[g]),
      .done_o      (done_o[g]),
      .rise_o      (rise[g])
    );
  end

  always_comb begin
    sum = SW'(peak_q);
    for (int i = 0; i < NUM_CH; i++) sum = sum + SW'(rise[i]);
    if (peak_clr_i)          peak_d = '0;
    else if (sum > SW'(PMAX)) peak_d = PMAX;
    else                     peak_d = sum[PCBITS-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) peak_q <= '0;
    else         peak_q <= peak_d;
  end

  assign peak_cnt_o = peak_q;
endmodule

// File: tb/tb_load_store_multi.sv
// Directed bench for load_store_multi with two 4-bit channels, limit 5, 2-bit peak counter.
module tb_load_store_multi;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] en = '0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_ch = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_limit = '0;
  logic       peak_clr = 1'b0;
  logic [7:0] vol;
  logic [1:0] dir, sig, done;
  logic [1:0] peak;
  logic [3:0] v0, v1;
  int checks = 0;
  int errors = 0;

  assign v0 = vol[3:0];
  assign v1 = vol[7:4];

  load_store_multi #(.NUM_CH(2), .CBITS(4), .N(5), .PCBITS(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
    .cfg_mode_i(cfg_mode), .cfg_limit_i(cfg_limit), .peak_clr_i(peak_clr),
    .vol_o(vol), .dir_o(dir), .sig_o(sig), .done_o(done), .peak_cnt_o(peak)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] ch, input logic [1:0] m, input logic [3:0] lim, input logic [1:0] e);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_limit = lim; en = e;
    tick();
    cfg_we = 1'b0; en = '0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (vol !== 8'h00 || dir !== 2'b00 || sig !== 2'b00 || done !== 2'b00 || peak !== 2'd0) begin
      errors++;
      $display("FAIL reset vol=%h dir=%b sig=%b done=%b peak=%0d exp all zero", vol, dir, sig, done, peak);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_triangle();
    logic [3:0] ev [13] = '{0,1,2,3,4,5,5,4,3,2,1,0,0};
    logic       ed [13] = '{1,1,1,1,1,1,0,0,0,0,0,0,1};
    en = 2'b01;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (v0 !== ev[i] || dir[0] !== ed[i] || sig[0] !== (ev[i] == 4'd5) || v1 !== 4'd0) begin
        errors++;
        $display("FAIL tri step %0d v0=%0d dir=%b sig=%b v1=%0d exp v0=%0d dir=%b sig=%b v1=0",
                 i, v0, dir[0], sig[0], v1, ev[i], ed[i], ev[i] == 4'd5);
      end
    end
    en = '0;
    checks++;
    if (peak !== 2'd1) begin errors++; $display("FAIL tri_peak got %0d exp 1", peak); end
  endtask

  task automatic test_saw();
    logic [3:0] ev [9] = '{1,2,3,0,1,2,3,0,1};
    cfg(4'd1, 2'd1, 4'd3, 2'b00);
    checks++;
    if (v1 !== 4'd0 || dir[1] !== 1'b0 || sig[1] !== 1'b0) begin
      errors++; $display("FAIL saw_cfg v1=%0d dir=%b sig=%b exp 0 0 0", v1, dir[1], sig[1]);
    end
    en = 2'b10;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (v1 !== ev[i] || dir[1] !== 1'b1 || sig[1] !== (ev[i] == 4'd3) || v0 !== 4'd0) begin
        errors++;
        $display("FAIL saw step %0d v1=%0d dir=%b sig=%b v0=%0d exp v1=%0d dir=1 sig=%b v0=0",
                 i, v1, dir[1], sig[1], v0, ev[i], ev[i] == 4'd3);
      end
    end
    en = '0;
    checks++;
    if (peak !== 2'd3) begin errors++; $display("FAIL saw_peak got %0d exp 3", peak); end
  endtask

  task automatic test_oneshot();
    logic [3:0] ev [5] = '{1,2,2,2,2};
    peak_clr = 1'b1; tick(); peak_clr = 1'b0;
    checks++;
    if (peak !== 2'd0) begin errors++; $display("FAIL peak_clr got %0d exp 0", peak); end
    cfg(4'd0, 2'd2, 4'd2, 2'b00);
    en = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (v0 !== ev[i] || done[0] !== (i >= 1) || sig[0] !== (i >= 1) || v1 !== 4'd1 || done[1] !== 1'b0) begin
        errors++;
        $display("FAIL one step %0d v0=%0d done=%b sig=%b v1=%0d exp v0=%0d done=%b sig=%b v1=1",
                 i, v0, done, sig[0], v1, ev[i], i >= 1, i >= 1);
      end
    end
    en = '0;
    checks++;
    if (peak !== 2'd1) begin errors++; $display("FAIL one_peak got %0d exp 1", peak); end
  endtask

  task automatic test_cfg_collision();
    cfg(4'd0, 2'd0, 4'd5, 2'b01);
    checks++;
    if (v0 !== 4'd0 || dir[0] !== 1'b0 || done[0] !== 1'b0 || sig[0] !== 1'b0) begin
      errors++; $display("FAIL col_done v0=%0d dir=%b done=%b sig=%b exp 0 0 0 0", v0, dir[0], done[0], sig[0]);
    end
    en = 2'b01;
    repeat (3) tick();
    checks++;
    if (v0 !== 4'd2 || dir[0] !== 1'b1) begin
      errors++; $display("FAIL col_mid v0=%0d dir=%b exp 2 1", v0, dir[0]);
    end
    cfg(4'd0, 2'd1, 4'd4, 2'b01);
    checks++;
    if (v0 !== 4'd0 || dir[0] !== 1'b0) begin
      errors++; $display("FAIL col_cfg v0=%0d dir=%b exp 0 0", v0, dir[0]);
    end
    en = 2'b01; tick(); en = '0;
    checks++;
    if (v0 !== 4'd1 || dir[0] !== 1'b1) begin
      errors++; $display("FAIL col_newmode v0=%0d dir=%b exp 1 1", v0, dir[0]);
    end
    cfg(4'd7, 2'd3, 4'd0, 2'b00);
    checks++;
    if (v0 !== 4'd1 || v1 !== 4'd1 || sig !== 2'b00 || dir !== 2'b11 || peak !== 2'd1) begin
      errors++; $display("FAIL col_drop v0=%0d v1=%0d sig=%b dir=%b peak=%0d exp 1 1 00 11 1", v0, v1, sig, dir, peak);
    end
    en = 2'b01; tick(); en = '0;
    checks++;
    if (v0 !== 4'd2) begin errors++; $display("FAIL col_drop_mode v0=%0d exp 2", v0); end
  endtask

  task automatic test_saturate();
    logic [1:0] ep [5] = '{3,3,3,3,0};
    logic [3:0] e1 [5] = '{1,0,1,0,1};
    peak_clr = 1'b1; tick(); peak_clr = 1'b0;
    cfg(4'd0, 2'd1, 4'd0, 2'b00);
    cfg(4'd1, 2'd1, 4'd0, 2'b00);
    checks++;
    if (sig !== 2'b11 || peak !== 2'd2) begin
      errors++; $display("FAIL sat_cfg0 sig=%b peak=%0d exp 11 2", sig, peak);
    end
    en = 2'b11; tick(); en = '0;
    checks++;
    if (v0 !== 4'd0 || v1 !== 4'd0 || sig !== 2'b11 || peak !== 2'd2) begin
      errors++; $display("FAIL sat_hold v0=%0d v1=%0d sig=%b peak=%0d exp 0 0 11 2", v0, v1, sig, peak);
    end
    cfg(4'd1, 2'd1, 4'd1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      en = 2'b11; peak_clr = (i == 4);
      tick();
      checks++;
      if (v1 !== e1[i] || v0 !== 4'd0 || sig[1] !== e1[i][0] || peak !== ep[i]) begin
        errors++;
        $display("FAIL sat step %0d v1=%0d v0=%0d sig1=%b peak=%0d exp v1=%0d v0=0 sig1=%b peak=%0d",
                 i, v1, v0, sig[1], peak, e1[i], e1[i][0], ep[i]);
      end
    end
    en = '0; peak_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] ev [7] = '{0,1,2,3,4,5,5};
    cfg(4'd0, 2'd2, 4'd1, 2'b00);
    en = 2'b11; repeat (3) tick(); en = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vol !== 8'h00 || dir !== 2'b00 || sig !== 2'b00 || done !== 2'b00 || peak !== 2'd0) begin
      errors++;
      $display("FAIL async_rst vol=%h dir=%b sig=%b done=%b peak=%0d exp all zero", vol, dir, sig, done, peak);
    end
    #1 rst_n = 1'b1;
    en = 2'b01;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (v0 !== ev[i] || dir[0] !== (i < 6) || sig[0] !== (ev[i] == 4'd5)) begin
        errors++;
        $display("FAIL rst_lim step %0d v0=%0d dir=%b sig=%b exp v0=%0d dir=%b sig=%b",
                 i, v0, dir[0], sig[0], ev[i], i < 6, ev[i] == 4'd5);
      end
    end
    en = '0;
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_saw();
    test_oneshot();
    test_cfg_collision();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
